// File: rtl/ddr5_cmd_pkg.sv
// DDR5 column-command codes, scheduler state type and latency helpers.
// Shared by the slot scheduler (vac_slot_sched, optional VAC_SLIP_STATS_EN) and its bench.
package ddr5_cmd_pkg;

  localparam logic [3:0] CS_WR   = 4'b0111;
  localparam logic [3:0] CS_WRA  = 4'b0101;
  localparam logic [3:0] CS_RD   = 4'b0100;
  localparam logic [3:0] CS_RDA  = 4'b1100;
  localparam logic [3:0] CS_ACTC = 4'b1001;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } sched_state_e;

  function automatic logic is_data(input logic [3:0] cs);
    return (cs == CS_WR) || (cs == CS_WRA) || (cs == CS_RD) || (cs == CS_RDA);
  endfunction

  function automatic logic is_write(input logic [3:0] cs);
    return (cs == CS_WR) || (cs == CS_WRA);
  endfunction

  // Data latency in cycles from issue to first beat; 0 for non-data codes.
  function automatic int lat_of(input logic [3:0] cs, input int cl, input int cla, input int wl_off);
    case (cs)
      CS_RD:   return cl;
      CS_RDA:  return cla;
      CS_WR:   return cl - wl_off;
      CS_WRA:  return cla - wl_off;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/dq_timeline.sv
// Shifting DQ-slot timeline: occupancy, direction and tag per future slot.
// Slot 0 is the beat on DQ this cycle; bookings land in post-shift positions.
module dq_timeline #(
  parameter int DEPTH = 16,
  parameter int TAG_W = 4,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             book_en,
  input  logic [IDX_W-1:0] book_start,
  input  logic [2:0]       book_len,
  input  logic             book_rw,
  input  logic [TAG_W-1:0] book_tag,
  output logic [DEPTH-1:0] sh_occ,
  output logic [DEPTH-1:0] sh_rw,
  output logic             beat_valid,
  output logic             beat_rw,
  output logic [TAG_W-1:0] beat_tag
);

  logic [DEPTH-1:0] occ_q, occ_d, rw_q, rw_d, book_mask;
  logic [TAG_W-1:0] tag_q [DEPTH];
  logic [TAG_W-1:0] tag_d [DEPTH];

  always_comb begin
    book_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      book_mask[i] = book_en && (i >= int'(book_start)) &&
                     (i < int'(book_start) + int'(book_len));
    end
    sh_occ = occ_q >> 1;
    sh_rw  = rw_q >> 1;
    occ_d  = sh_occ | book_mask;
    rw_d   = (sh_rw & ~book_mask) | (book_mask & {DEPTH{book_rw}});
    for (int i = 0; i < DEPTH - 1; i++) begin
      tag_d[i] = book_mask[i] ? book_tag : tag_q[i+1];
    end
    tag_d[DEPTH-1] = book_mask[DEPTH-1] ? book_tag : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q <= '0;
      rw_q  <= '0;
      for (int i = 0; i < DEPTH; i++) tag_q[i] <= '0;
    end else begin
      occ_q <= occ_d;
      rw_q  <= rw_d;
      for (int i = 0; i < DEPTH; i++) tag_q[i] <= tag_d[i];
    end
  end

  // A booking must never land on a slot that is still occupied after the shift.
  always_ff @(posedge clk) begin
    if (rst && book_en) begin
      assert ((sh_occ & book_mask) == '0);
    end
  end

  assign beat_valid = occ_q[0];
  assign beat_rw    = rw_q[0];
  assign beat_tag   = tag_q[0];

endmodule

// File: rtl/vac_slot_sched.sv
// Data-bus slot scheduler: holds one column command and issues it once its burst fits the DQ timeline.
// Optional VAC_SLIP_STATS_EN adds slip_cnt/slip_max stall statistics.
module vac_slot_sched #(
  parameter int CL     = 4,
  parameter int CLA    = 6,
  parameter int WL_OFF = 2,
  parameter int CL_MAX = 16,
  parameter int BURST  = 2,
  parameter int TA_GAP = 1,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [3:0]        C_S,
  input  logic [TAG_W-1:0]  cmd_tag,
  output logic              cmd_ready,
  output logic              issue,
  output logic [CL_MAX-1:0] mux_sel,
  output logic              beat_valid,
  output logic              beat_rw,
  output logic [TAG_W-1:0]  beat_tag,
  output logic              dbg_state
`ifdef VAC_SLIP_STATS_EN
  ,
  output logic [15:0]       slip_cnt,
  output logic [7:0]        slip_max
`endif
);
  import ddr5_cmd_pkg::*;

  localparam int IDX_W = $clog2(CL_MAX);

  sched_state_e     state_q, state_d;
  logic [3:0]       code_q, code_d;
  logic [TAG_W-1:0] ctag_q, ctag_d;
  logic [CL_MAX-1:0] sh_occ, sh_rw;
  logic             book_en, fit, hold_wr;
  int               start;

  // Handshake: a command transfers on a cycle with cmd_valid && cmd_ready; cmd_ready is
  // a pure function of state (high only in IDLE), so there is no valid->ready path.
  assign cmd_ready = (state_q == ST_IDLE);
  assign dbg_state = state_q;

  // Fit check of the single start slot implied by the held command's latency.
  always_comb begin
    start   = lat_of(code_q, CL, CLA, WL_OFF) - 1;
    hold_wr = is_write(code_q);
    fit     = 1'b1;
    for (int i = 0; i < CL_MAX; i++) begin
      if (sh_occ[i]) begin
        if (i >= start && i < start + BURST) fit = 1'b0;
        if ((sh_rw[i] != hold_wr) &&
            ((i >= start - TA_GAP && i < start) ||
             (i >= start + BURST && i < start + BURST + TA_GAP))) fit = 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    ctag_d  = ctag_q;
    issue   = 1'b0;
    mux_sel = '0;
    book_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          code_d  = C_S;
          ctag_d  = cmd_tag;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!is_data(code_q)) begin
          issue   = 1'b1;
          state_d = ST_IDLE;
        end else if (fit) begin
          issue   = 1'b1;
          book_en = 1'b1;
          state_d = ST_IDLE;
          for (int i = 0; i < CL_MAX; i++) mux_sel[i] = (i == start);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      code_q  <= '0;
      ctag_q  <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      ctag_q  <= ctag_d;
    end
  end

  dq_timeline #(
    .DEPTH(CL_MAX),
    .TAG_W(TAG_W),
    .IDX_W(IDX_W)
  ) u_timeline (
    .clk       (clk),
    .rst       (rst),
    .book_en   (book_en),
    .book_start(IDX_W'(start)),
    .book_len  (3'(BURST)),
    .book_rw   (hold_wr),
    .book_tag  (ctag_q),
    .sh_occ    (sh_occ),
    .sh_rw     (sh_rw),
    .beat_valid(beat_valid),
    .beat_rw   (beat_rw),
    .beat_tag  (beat_tag)
  );

`ifdef VAC_SLIP_STATS_EN
  logic [15:0] slip_cnt_q, slip_cnt_d;
  logic [7:0]  wait_q, wait_d, slip_max_q, slip_max_d;
  logic        stall;

  // wait_q tracks the current command's stall run; it restarts whenever the block is idle.
  always_comb begin
    stall      = (state_q == ST_HOLD) && is_data(code_q) && !fit;
    slip_cnt_d = (stall && slip_cnt_q != 16'hFFFF) ? slip_cnt_q + 16'd1 : slip_cnt_q;
    if (state_q == ST_IDLE) wait_d = '0;
    else if (stall && wait_q != 8'hFF) wait_d = wait_q + 8'd1;
    else wait_d = wait_q;
    slip_max_d = (wait_d > slip_max_q) ? wait_d : slip_max_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slip_cnt_q <= '0;
      wait_q     <= '0;
      slip_max_q <= '0;
    end else begin
      slip_cnt_q <= slip_cnt_d;
      wait_q     <= wait_d;
      slip_max_q <= slip_max_d;
    end
  end

  assign slip_cnt = slip_cnt_q;
  assign slip_max = slip_max_q;
`endif

endmodule

// File: tb/tb_vac_slot_sched.sv
// Bench for vac_slot_sched: directed scenarios plus random traffic against an absolute-time slot model.
// Define VAC_SLIP_STATS_EN to also check the stall statistics outputs.
module tb_vac_slot_sched;
  import ddr5_cmd_pkg::*;

  localparam int CL = 4, CLA = 6, WL_OFF = 2, CL_MAX = 16, BURST = 2, TA_GAP = 1, TAG_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cmd_valid = 1'b0;
  logic [3:0]        c_s = '0;
  logic [TAG_W-1:0]  cmd_tag = '0;
  logic              cmd_ready, issue, beat_valid, beat_rw, dbg_state;
  logic [CL_MAX-1:0] mux_sel;
  logic [TAG_W-1:0]  beat_tag;
`ifdef VAC_SLIP_STATS_EN
  logic [15:0]       slip_cnt;
  logic [7:0]        slip_max;
`endif

  always #5 clk = ~clk;

  vac_slot_sched #(
    .CL(CL), .CLA(CLA), .WL_OFF(WL_OFF), .CL_MAX(CL_MAX),
    .BURST(BURST), .TA_GAP(TA_GAP), .TAG_W(TAG_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .C_S       (c_s),
    .cmd_tag   (cmd_tag),
    .cmd_ready (cmd_ready),
    .issue     (issue),
    .mux_sel   (mux_sel),
    .beat_valid(beat_valid),
    .beat_rw   (beat_rw),
    .beat_tag  (beat_tag),
    .dbg_state (dbg_state)
`ifdef VAC_SLIP_STATS_EN
    ,
    .slip_cnt  (slip_cnt),
    .slip_max  (slip_max)
`endif
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  // Reference model: bookings keyed by the absolute cycle on which the beat is on DQ.
  bit               m_hold;
  logic [3:0]       m_code;
  logic [TAG_W-1:0] m_tag;
  bit               bk_rw [int];
  logic [TAG_W-1:0] bk_tag [int];
  int               m_slip, m_wait, m_smax;
  logic [TAG_W-1:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", name, cyc, obs, exp);
    end
  endtask

  function automatic int m_lat(input logic [3:0] cs);
    case (cs)
      CS_RD:   return CL;
      CS_RDA:  return CLA;
      CS_WR:   return CL - WL_OFF;
      CS_WRA:  return CLA - WL_OFF;
      default: return 0;
    endcase
  endfunction

  function automatic bit m_is_wr(input logic [3:0] cs);
    return (cs == CS_WR) || (cs == CS_WRA);
  endfunction

  // Beats for a grant on cycle t occupy cycles t+lat .. t+lat+BURST-1.
  function automatic bit fits(input int t, input int lat, input bit wr);
    int b;
    b = t + lat;
    for (int c = b; c < b + BURST; c++)
      if (bk_rw.exists(c)) return 1'b0;
    for (int c = b - TA_GAP; c < b; c++)
      if (c > t && bk_rw.exists(c) && bk_rw[c] != wr) return 1'b0;
    for (int c = b + BURST; c < b + BURST + TA_GAP; c++)
      if (bk_rw.exists(c) && bk_rw[c] != wr) return 1'b0;
    return 1'b1;
  endfunction

  // Checks one cycle (called mid-cycle with inputs already driven), then advances the model.
  task automatic tick();
    bit                exp_issue, has_beat;
    logic [CL_MAX-1:0] exp_mux;
    int                lat;
    exp_issue = 1'b0;
    exp_mux   = '0;
    lat       = m_lat(m_code);
    if (m_hold) begin
      if (lat == 0) exp_issue = 1'b1;
      else if (fits(cyc, lat, m_is_wr(m_code))) begin
        exp_issue = 1'b1;
        exp_mux   = CL_MAX'(1) << (lat - 1);
      end
    end
    has_beat = bk_rw.exists(cyc);
    chk("cmd_ready", 32'(cmd_ready), 32'(!m_hold));
    chk("issue", 32'(issue), 32'(exp_issue));
    chk("mux_sel", 32'(mux_sel), 32'(exp_mux));
    chk("beat_valid", 32'(beat_valid), 32'(has_beat));
    chk("beat_rw", 32'(beat_rw), has_beat ? 32'(bk_rw[cyc]) : 32'd0);
    chk("beat_tag", 32'(beat_tag), has_beat ? 32'(bk_tag[cyc]) : 32'd0);
    if (m_hold) begin
      if (exp_issue) begin
        m_hold = 1'b0;
        m_wait = 0;
        if (lat != 0) begin
          for (int k = 0; k < BURST; k++) begin
            bk_rw[cyc + lat + k]  = m_is_wr(m_code);
            bk_tag[cyc + lat + k] = m_tag;
          end
        end
      end else begin
        m_slip++;
        m_wait++;
        if (m_wait > m_smax) m_smax = m_wait;
      end
    end else if (cmd_valid) begin
      m_hold = 1'b1;
      m_code = c_s;
      m_tag  = cmd_tag;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    cmd_valid = 1'b0;
    rst = 1'b0;
    #1;
    m_hold = 1'b0;
    m_slip = 0;
    m_wait = 0;
    m_smax = 0;
    bk_rw.delete();
    bk_tag.delete();
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_issue", 32'(issue), 32'd0);
    chk("rst_beat", 32'(beat_valid), 32'd0);
    chk("rst_mux", 32'(mux_sel), 32'd0);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    chk("rst_ready2", 32'(cmd_ready), 32'd1);
    chk("rst_beat2", 32'(beat_valid), 32'd0);
    rst = 1'b1;
  endtask

  task automatic send(input logic [3:0] code, input logic [TAG_W-1:0] tag);
    int guard;
    cmd_valid = 1'b1;
    c_s       = code;
    cmd_tag   = tag;
    guard     = 0;
    while (m_hold && guard < 50) begin
      tick();
      guard++;
    end
    chk("hold_bound", 32'(guard < 50), 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Record the tag order seen on DQ and compare against the expected order.
  task automatic collect_tags(input int n);
    logic [TAG_W-1:0] got;
    for (int i = 0; i < n; i++) begin
      if (beat_valid && exp_q.size() != 0) begin
        got = exp_q.pop_front();
        chk("tag_order", 32'(beat_tag), 32'(got));
      end
      tick();
    end
    chk("tag_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [3:0] codes [6];
    @(negedge clk);
    apply_reset();

    // Single RD on an empty timeline.
    send(CS_RD, 4'd5);
    idle(8);

    // WR then RD, and RD then WR (second one must wait for the turnaround gap).
    send(CS_WR, 4'd1);
    send(CS_RD, 4'd2);
    idle(10);
    send(CS_RD, 4'd3);
    send(CS_WR, 4'd4);
    idle(12);

    // Two RDs back to back: beats contiguous, tags in order.
    exp_q.push_back(4'd6);
    exp_q.push_back(4'd6);
    exp_q.push_back(4'd7);
    exp_q.push_back(4'd7);
    send(CS_RD, 4'd6);
    send(CS_RD, 4'd7);
    collect_tags(12);

    // Non-data command: issue pulse only.
    send(CS_ACTC, 4'd8);
    idle(4);

    // Reset while a WR is held behind a booked RD.
    send(CS_RD, 4'd9);
    send(CS_WR, 4'd10);
    apply_reset();
    idle(8);

    // Random traffic.
    codes[0] = CS_WR;
    codes[1] = CS_WRA;
    codes[2] = CS_RD;
    codes[3] = CS_RDA;
    codes[4] = CS_ACTC;
    for (int i = 0; i < 400; i++) begin
      codes[5]  = 4'($urandom_range(0, 15));
      cmd_valid = 1'($urandom_range(0, 1));
      c_s       = codes[$urandom_range(0, 5)];
      cmd_tag   = TAG_W'($urandom_range(0, 15));
      tick();
    end
    cmd_valid = 1'b0;
    idle(20);

`ifdef VAC_SLIP_STATS_EN
    chk("slip_cnt", 32'(slip_cnt), 32'(m_slip));
    chk("slip_max", 32'(slip_max), 32'(m_smax));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
